// File: rtl/cache_mem_responder.sv
// Single-word memory responder below the cache refill/evict port.
// Optional request counters: define CACHE_MEM_RESPONDER_STATS_EN.
package cache_mem_pkg;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  localparam logic [2:0] MEM_READ  = 3'd0;
  localparam logic [2:0] MEM_WRITE = 3'd1;
  localparam logic [2:0] MEM_INIT  = 3'd2;

endpackage

module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int NUM_WORDS = 256,
  parameter int LATENCY   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memreq_val,
  output logic         memreq_rdy,
  input  mem_req_4B_t  memreq_msg,
  output logic         memresp_val,
  input  logic         memresp_rdy,
  output mem_resp_4B_t memresp_msg
`ifdef CACHE_MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]  num_reads,
  output logic [31:0]  num_writes
`endif
);

  localparam int IW = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         rdy_q, rdy_d;
  logic         val_q, val_d;
  mem_resp_4B_t msg_q, msg_d;

  logic [31:0]  mem [NUM_WORDS];

  logic [IW-1:0] idx;
  logic [1:0]    off;
  logic [4:0]    len_mask;
  logic [3:0]    wr_be;
  logic [31:0]   wr_word;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   rd_keep;
  logic [31:0]   rd_data;
  logic          accept;
  logic          is_rd;
  logic          is_wr;
  logic          unused_addr;

  assign idx    = memreq_msg.addr[IW+1:2];
  assign off    = memreq_msg.addr[1:0];
  assign accept = memreq_val && rdy_q && !reset;
  assign is_rd  = memreq_msg.type_ == MEM_READ;
  assign is_wr  = (memreq_msg.type_ == MEM_WRITE)
               || (memreq_msg.type_ == MEM_INIT);

  assign unused_addr = ^memreq_msg.addr[31:IW+2];

  // Byte lanes past 3 fall off the top of the 4-bit enable.
  always_comb begin
    len_mask = (memreq_msg.len == 2'd0)
             ? 5'b01111
             : (5'd1 << memreq_msg.len) - 5'd1;
    wr_be    = len_mask[3:0] << off;
    wr_word  = memreq_msg.data << {off, 3'b000};
    rd_word  = mem[idx];
    rd_shift = rd_word >> {off, 3'b000};
    rd_keep  = {{8{len_mask[3]}}, {8{len_mask[2]}},
                {8{len_mask[1]}}, {8{len_mask[0]}}};
    rd_data  = rd_shift & rd_keep;
  end

  always_ff @(posedge clk) begin
    if (accept && is_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    msg_d   = msg_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d        = 4'(LATENCY);
          msg_d.type_  = memreq_msg.type_;
          msg_d.opaque = memreq_msg.opaque;
          msg_d.test   = 2'd0;
          msg_d.len    = memreq_msg.len;
          unique case (1'b1)
            is_rd:   msg_d.data = rd_data;
            default: msg_d.data = 32'd0;
          endcase
          state_d = (LATENCY > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (memresp_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = state_d == IDLE;
    val_d = state_d == RESP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdy_q   <= 1'b1;
      val_q   <= 1'b0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      val_q   <= val_d;
      msg_q   <= msg_d;
    end
  end

  assign memreq_rdy  = rdy_q;
  assign memresp_val = val_q;
  assign memresp_msg = msg_q;

`ifdef CACHE_MEM_RESPONDER_STATS_EN
  logic [31:0] num_reads_q, num_reads_d;
  logic [31:0] num_writes_q, num_writes_d;

  always_comb begin
    num_reads_d  = num_reads_q;
    num_writes_d = num_writes_q;
    if (accept && is_rd) num_reads_d  = num_reads_q + 32'd1;
    if (accept && is_wr) num_writes_d = num_writes_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num_reads_q  <= 32'd0;
      num_writes_q <= 32'd0;
    end else begin
      num_reads_q  <= num_reads_d;
      num_writes_q <= num_writes_d;
    end
  end

  assign num_reads  = num_reads_q;
  assign num_writes = num_writes_q;
`endif

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Memory-side responder for the cache's refill/evict port. Accepts one mem_req_4B_t at a time from a cache controller, performs it against an internal word array after a programmable latency, and returns a mem_resp_4B_t.
- Sits below the cache in unit tests and in the cache+memory composition, replacing the external test memory.
- Handles one word per transaction. Line refills and evictions arrive as back-to-back single-word requests.

Parameters:
- NUM_WORDS, 256, depth of backing store in 32-bit words; power of two, at least 4.
- LATENCY, 2, extra wait cycles between request accept and response valid; range 0..15.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- memreq_val  input  1  request valid from cache.
- memreq_rdy  output  1  responder can accept a request.
- memreq_msg  input  mem_req_4B_t  type_, opaque, addr, len, data.
- memresp_val  output  1  response valid.
- memresp_rdy  input  1  cache can take the response.
- memresp_msg  output  mem_resp_4B_t  type_, opaque, test, len, data.

Behaviour:
- Reset values: state IDLE, memreq_rdy=1, memresp_val=0, memresp_msg all zero, latency counter 0.
  - Array contents are not reset.
  - Reset mid-transaction drops the pending request with no response. A write already committed stays committed.
- FSM states IDLE, WAIT, RESP.
- IDLE: memreq_rdy=1.
  - On memreq_val, latch type_, opaque, addr, len, data and load the counter with LATENCY.
  - Next state is WAIT if LATENCY>0, otherwise RESP.
- WAIT: memreq_rdy=0. Counter decrements each cycle; go to RESP when the counter reaches 1.
- RESP: memresp_val=1 and memresp_msg is held stable until memresp_rdy.
  - On memresp_val && memresp_rdy, go to IDLE.
  - No new request is accepted in the handshake cycle. memreq_rdy rises the following cycle.
- Latency: accept in cycle N, memresp_val first high in cycle N+1+LATENCY. Minimum back-to-back throughput is one transaction per LATENCY+2 cycles.
- Word index is addr[log2(NUM_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo NUM_WORDS*4.
- Byte count: len 0 means 4 bytes; 1, 2, 3 mean that many bytes starting at byte addr[1:0].
  - Lanes past byte 3 are dropped; no crossing into the next word.
- WRITE and INIT (type_ 1 and 2): array updated in the accept cycle, byte-masked from data[8*i+7:8*i] into lane addr[1:0]+i.
  - Response data is 0.
- READ (type_ 0): array read at the accept cycle and latched.
  - Response data is the word shifted right by 8*addr[1:0], with bytes past len zeroed.
  - A write and a read are never in flight together, so there is no read-during-write case.
- Any other type_: no array access; response data is 0.
- Response fields: type_ echoes the request, opaque echoes, len echoes, test=0.
- memresp_rdy low in RESP holds the state indefinitely; memreq_val is ignored outside IDLE.

Optional Feature:
- Macro CACHE_MEM_RESPONDER_STATS_EN.
- When defined, the block adds output ports num_reads [31:0] and num_writes [31:0].
  - Both reset to 0.
  - num_reads increments on each accepted READ; num_writes increments on each accepted WRITE or INIT.
  - Both wrap at 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- INIT addr 0x100 data 0xDEADBEEF, then READ addr 0x100 len 0 -> response type_=READ, data=0xDEADBEEF, opaque echoed. memresp_val appears exactly 3 cycles after accept with LATENCY=2.
- Four WRITEs to 0x00, 0x04, 0x08, 0x0C with data 0x11, 0x22, 0x33, 0x44, then four READs -> 0x11, 0x22, 0x33, 0x44 in order. memreq_rdy is low from accept until the cycle after each response handshake.
- INIT 0x20 = 0xAABBCCDD, WRITE addr 0x21 len 1 data 0xEE, READ 0x20 len 0 -> 0xAABBEEDD. READ addr 0x22 len 2 -> 0x0000AABB.
- memresp_rdy held low 5 cycles during RESP -> memresp_val stays 1 and memresp_msg is unchanged each cycle; the transaction completes on the cycle memresp_rdy rises.
- NUM_WORDS=256: WRITE addr 0x400 data 0x5, READ addr 0x000 -> 0x5 (wrap). LATENCY=0 -> response the cycle after accept.
- Reset asserted in WAIT after a READ -> no response emitted, memreq_rdy=1 the cycle after reset deasserts. With STATS_EN, num_reads=0 after reset and 1 after the next READ.
